// File: rtl/booth_arbiter.sv
// booth_arbiter: arbitrates four voting booths onto one set of saturating tallies.
// A vote moves OPEN -> GRANT (booth and candidate latched) -> COMMIT (tallied, acked).
// Optional feature macro: BOOTH_RR_ARB_EN selects round-robin arbitration;
// when it is undefined, booth 0 has fixed highest priority.
module booth_arbiter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          open,
    input  logic          close,
    input  logic          clear,
    input  logic [3:0]    req,
    input  logic [7:0]    cand,
    output logic [3:0]    ack,
    output logic          session_open,
    output logic          busy,
    output logic [CW-1:0] count1,
    output logic [CW-1:0] count2,
    output logic [CW-1:0] count3,
    output logic [CW-1:0] count4,
    output logic [CW+1:0] total,
    output logic          sat,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_OPEN   = 3'b001,
        S_GRANT  = 3'b010,
        S_COMMIT = 3'b011,
        S_CLOSED = 3'b100
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 grant_go;
    logic [1:0]           win;
    logic [1:0]           booth_q;
    logic [1:0]           cand_q;
    logic                 close_seen;
    logic [3:0][CW-1:0]   tally;
    logic                 admin_clear;

    // A tally sticks at its maximum once reached; callers detect that case for sat.
    function automatic logic [CW-1:0] tally_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The running total saturates independently of the per-candidate tallies.
    function automatic logic [CW+1:0] total_inc(input logic [CW+1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef BOOTH_RR_ARB_EN
    logic [1:0] rr_last;

    // Search begins one past the last granted booth and wraps 3 -> 0.
    function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign win = pick_rr(req, rr_last);

    // Pointer follows the booth that has just been granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_last <= 2'd3;
        else if (grant_go)
            rr_last <= win;
    end
`else
    // Lowest-numbered requesting booth wins.
    function automatic logic [1:0] pick_fixed(input logic [3:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else if (r[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign win = pick_fixed(req);
`endif

    // Session control: close beats open and req while OPEN; unknown codes recover to IDLE.
    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        case (state)
            S_IDLE: begin
                if (open)
                    state_nxt = S_OPEN;
            end
            S_OPEN: begin
                if (close) begin
                    state_nxt = S_CLOSED;
                end else if (|req) begin
                    state_nxt = S_GRANT;
                    grant_go  = 1'b1;
                end
            end
            S_GRANT: begin
                state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                if (close_seen || close)
                    state_nxt = S_CLOSED;
                else
                    state_nxt = S_OPEN;
            end
            S_CLOSED: begin
                if (open)
                    state_nxt = S_OPEN;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Latch the winning booth and its code on entry to GRANT; later req changes cannot alter it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            booth_q <= 2'd0;
            cand_q  <= 2'd0;
        end else if (grant_go) begin
            booth_q <= win;
            cand_q  <= cand[{win, 1'b0} +: 2];
        end
    end

    // Remember a close seen during GRANT so COMMIT can route to CLOSED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            close_seen <= 1'b0;
        else if (state == S_GRANT)
            close_seen <= close;
    end

    assign admin_clear = clear && ((state == S_IDLE) || (state == S_CLOSED));

    // Tallies: zeroed by clear only while no session is running, bumped at the end of COMMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tally <= '0;
            total <= '0;
            sat   <= 1'b0;
        end else if (admin_clear) begin
            tally <= '0;
            total <= '0;
            sat   <= 1'b0;
        end else if (state == S_COMMIT) begin
            tally[cand_q] <= tally_inc(tally[cand_q]);
            total         <= total_inc(total);
            if (&tally[cand_q])
                sat <= 1'b1;
        end
    end

    // Ack is decoded from the registered state, so a reset during COMMIT removes it at once.
    assign ack          = (state == S_COMMIT) ? (4'b0001 << booth_q) : 4'b0000;
    assign session_open = (state == S_OPEN) || (state == S_GRANT) || (state == S_COMMIT);
    assign busy         = (state == S_GRANT) || (state == S_COMMIT);
    assign state_dbg    = state;
    assign count1       = tally[0];
    assign count2       = tally[1];
    assign count3       = tally[2];
    assign count4       = tally[3];

endmodule

// File: tb/tb_booth_arbiter.sv
// Testbench for booth_arbiter (CW=4): directed scenarios plus randomized traffic
// against a vote-level reference model. Honours BOOTH_RR_ARB_EN if defined.
module tb_booth_arbiter;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << (CW + 2)) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          open = 1'b0;
    logic          close = 1'b0;
    logic          clear = 1'b0;
    logic [3:0]    req = 4'b0;
    logic [7:0]    cand = 8'b0;
    logic [3:0]    ack;
    logic          session_open;
    logic          busy;
    logic [CW-1:0] count1, count2, count3, count4;
    logic [CW+1:0] total;
    logic          sat;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: session flag, vote progress, tallies
    bit         m_open;
    int         m_phase;   // 0 none, 1 vote latched, 2 vote committing
    bit         m_cseen;
    int         m_booth;
    int         m_cand;
    int         m_last;
    int         m_cnt[4];
    int         m_total;
    bit         m_sat;
    logic [3:0] m_ack;

    booth_arbiter #(.CW(CW)) dut (
        .clk(clk), .reset(reset), .open(open), .close(close), .clear(clear),
        .req(req), .cand(cand), .ack(ack), .session_open(session_open), .busy(busy),
        .count1(count1), .count2(count2), .count3(count3), .count4(count4),
        .total(total), .sat(sat), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int arb(input logic [3:0] r);
`ifdef BOOTH_RR_ARB_EN
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (r[i]) return i;
        end
`else
        for (int i = 0; i < 4; i++)
            if (r[i]) return i;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_open = 0; m_phase = 0; m_cseen = 0; m_booth = 0; m_cand = 0; m_last = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_total = 0; m_sat = 0; m_ack = 4'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [7:0] c,
                              input logic op, input logic cl, input logic clr);
        if (!m_open) begin
            if (clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                m_total = 0; m_sat = 0;
            end
            if (op) m_open = 1;
        end else if (m_phase == 0) begin
            if (cl) m_open = 0;
            else if (r != 4'b0) begin
                m_booth = arb(r);
                m_cand  = int'(c[2*m_booth +: 2]);
                m_last  = m_booth;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_cseen = cl;
            m_phase = 2;
        end else begin
            if (m_cnt[m_cand] == CMAX) m_sat = 1;
            else m_cnt[m_cand]++;
            if (m_total < TMAX) m_total++;
            if (m_cseen || cl) m_open = 0;
            m_phase = 0;
        end
        m_ack = (m_phase == 2) ? (4'b0001 << m_booth) : 4'b0000;
    endtask

    // one clock: model advances on the inputs present at the edge, then outputs are compared
    task automatic tick();
        logic [3:0] r; logic [7:0] c; logic op, cl, clr, rs;
        r = req; c = cand; op = open; cl = close; clr = clear; rs = reset;
        @(posedge clk);
        #1;
        if (rs) model_reset();
        else model_step(r, c, op, cl, clr);
        check("ack", 32'(ack), 32'(m_ack));
        check("session_open", 32'(session_open), 32'(m_open));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("tallies", 32'({count4, count3, count2, count1}),
              32'({m_cnt[3][CW-1:0], m_cnt[2][CW-1:0], m_cnt[1][CW-1:0], m_cnt[0][CW-1:0]}));
        check("total_sat", 32'({total, sat}), 32'({m_total[CW+1:0], m_sat}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int seq[$];
        model_reset();
        // reset state
        #2;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        check("rst_open_busy", 32'({session_open, busy}), 32'h0);
        check("rst_counts", 32'({count4, count3, count2, count1, total, sat}), 32'h0);
        do_reset();

        // single vote: booth 0, code 10
        open = 1'b1; tick(); open = 1'b0;
        check("open_state", 32'(state_dbg), 32'h1);
        req = 4'b0001; cand = 8'b0000_0010;
        tick();
        check("grant_state", 32'(state_dbg), 32'h2);
        check("grant_noack", 32'(ack), 32'h0);
        tick();
        check("lat_ack", 32'(ack), 32'h1);
        req = 4'b0;
        tick();
        check("count3", 32'(count3), 32'h1);
        check("total1", 32'(total), 32'h1);

        // all booths requesting, code 00, held for 12 cycles
        do_reset();
        open = 1'b1; tick(); open = 1'b0;
        req = 4'b1111; cand = 8'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            for (int i = 0; i < 4; i++) if (ack[i]) seq.push_back(i);
        end
        check("acks_seen", 32'(seq.size()), 32'h4);
        for (int j = 0; j < 4 && j < seq.size(); j++) begin
`ifdef BOOTH_RR_ARB_EN
            check("rr_order", 32'(seq[j]), 32'(j));
`else
            check("fixed_order", 32'(seq[j]), 32'h0);
`endif
        end
        check("count1_4", 32'(count1), 32'h4);
        req = 4'b0;

        // close during GRANT
        req = 4'b0010; cand = 8'b0000_1100;
        tick();
        close = 1'b1;
        tick();
        check("close_ack", 32'(ack), 32'h2);
        close = 1'b0; req = 4'b0;
        tick();
        check("closed_state", 32'(state_dbg), 32'h4);
        check("count4", 32'(count4), 32'h1);
        open = 1'b1; tick(); open = 1'b0;
        check("reopen_state", 32'(state_dbg), 32'h1);
        check("reopen_keep", 32'({count4, count1}), 32'h14);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_open_keep", 32'({count4, count1, total}), 32'(8'h14 * 64 + 5));
        close = 1'b1; tick(); close = 1'b0;
        check("closed2", 32'(state_dbg), 32'h4);
        clear = 1'b1; open = 1'b1; tick(); clear = 1'b0; open = 1'b0;
        check("clear_open_state", 32'(state_dbg), 32'h1);
        check("clear_closed", 32'({count4, count3, count2, count1, total, sat}), 32'h0);

        // saturation: 16 votes for code 01 from booth 2
        cand = 8'b0001_0000;
        for (int v = 0; v < 16; v++) begin
            req = 4'b0100; tick(); tick(); req = 4'b0; tick();
        end
        check("sat_count2", 32'(count2), 32'(CMAX));
        check("sat_flag", 32'(sat), 32'h1);
        check("sat_total", 32'(total), 32'd16);

        // reset during COMMIT
        req = 4'b0001; cand = 8'b0;
        tick(); tick();
        check("pre_rst_ack", 32'(ack), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_commit_ack", 32'(ack), 32'h0);
        check("rst_commit_state", 32'(state_dbg), 32'h0);
        check("rst_commit_counts", 32'({count4, count3, count2, count1, total, sat}), 32'h0);
        req = 4'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_state", 32'(state_dbg), 32'h0);

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (req[i]) begin
                    if ($urandom_range(15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    cand[2*i +: 2] = 2'($urandom_range(3));
                end
            end
            open  = ($urandom_range(19) == 0);
            close = ($urandom_range(24) == 0);
            clear = ($urandom_range(29) == 0);
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter CW, default 8, tally counter width in bits; range 4..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 open  input  1  admin: open or reopen the voting session.
REQ-005 close  input  1  admin: close the voting session.
REQ-006 clear  input  1  admin: zero all tallies; honoured only in IDLE or CLOSED.
REQ-007 req  input  4  per-booth commit request; booth i holds req[i] high until ack[i].
REQ-008 cand  input  8  per-booth candidate code; cand[2i+1:2i] is booth i's code, valid while req[i] high.
REQ-009 ack  output  4  one-hot, one-cycle pulse; the vote of booth i has been tallied.
REQ-010 session_open  output  1  high in OPEN, GRANT and COMMIT.
REQ-011 busy  output  1  high in GRANT and COMMIT.
REQ-012 count1..count4  output  CW each  tallies for candidate codes 00, 01, 10, 11.
REQ-013 total  output  CW+2  sum of all committed votes.
REQ-014 sat  output  1  sticky: some tally has saturated.
REQ-015 state_dbg  output  3  encoded FSM state for the debug LEDs.

Function
REQ-016 FSM states and encodings: IDLE=000, OPEN=001, GRANT=010, COMMIT=011, CLOSED=100; unused codes return to IDLE.
REQ-017 IDLE: open -> OPEN; clear zeroes the tallies, total and sat; otherwise stay.
REQ-018 OPEN: close -> CLOSED, with close taking priority over open and over req; else any req bit -> GRANT; else stay.
REQ-019 Entering GRANT latches the winning booth index and that booth's 2-bit cand code.
REQ-020 GRANT -> COMMIT unconditionally.
REQ-021 In COMMIT, the latched candidate's tally increments, total increments, and ack of the latched booth pulses for exactly one cycle.
REQ-022 Next state after COMMIT: CLOSED if close was seen high in GRANT or COMMIT, else OPEN.
REQ-023 Latency: req seen in OPEN at cycle t produces ack at cycle t+2.
REQ-024 Peak throughput is one vote per 3 cycles.
REQ-025 A latched vote always commits, even if its req drops after GRANT.
REQ-026 A req dropped before being latched is not tallied.
REQ-027 CLOSED: open -> OPEN with tallies retained; clear zeroes tallies, total and sat; close is ignored.
REQ-028 If clear and open are high together in IDLE or CLOSED, clear applies and the transition to OPEN occurs.
REQ-029 A tally at 2^CW-1 holds its value on a further vote and sets sat; total still increments.
REQ-030 total saturates at 2^(CW+2)-1.
REQ-031 Non-granted booths keep req high and receive no ack.
REQ-032 ack is never asserted outside COMMIT.
REQ-033 At most one ack bit is high in any cycle.

Reset
REQ-034 On reset: state=IDLE, ack=0, session_open=0, busy=0, count1..count4=0, total=0, sat=0, latched booth/cand=0, round-robin pointer=3.
REQ-035 Reset mid-COMMIT discards the vote being committed, and no ack is issued.
REQ-036 Outputs take their reset values asynchronously on reset assertion.
REQ-037 The first state update after reset deassertion occurs on the following rising edge of clk.

Configuration
REQ-038 Macro BOOTH_RR_ARB_EN defined: round-robin arbitration; the search starts at the booth after the last granted booth and wraps from 3 to 0.
REQ-039 Round-robin pointer updates on entry to GRANT.
REQ-040 BOOTH_RR_ARB_EN undefined: fixed priority, booth 0 highest and booth 3 lowest; no pointer register.

Verification
REQ-041 Reset, open, req=0001, cand[1:0]=10 -> ack=0001 two cycles after req seen; count3=1; total=1.
REQ-042 req=1111 held with all codes 00 and BOOTH_RR_ARB_EN defined -> acks in booth order 0,1,2,3; count1=4 after 12 cycles. Same stimulus without the macro -> booth 0 granted each time while req[0] stays high.
REQ-043 close asserted during GRANT -> the vote commits, ack pulses, then state=CLOSED. open then -> OPEN with tallies unchanged.
REQ-044 CW=4, 16 votes for code 01 -> count2=15, sat=1, total=16.
REQ-045 reset asserted during COMMIT -> no ack, all tallies 0, state=IDLE.
REQ-046 clear asserted in OPEN -> tallies unchanged. clear in CLOSED -> all tallies, total and sat cleared.
